// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: memory-stage FSM states and register selects.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef logic [4:0] reg_sel_t;

    // Word accesses must have the two low address bits clear.
    function automatic logic word_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: accepts one EX result at a time, performs an
// optional data-memory access, and emits a single-cycle writeback with
// overflow / alignment exception pulses.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic [31:0] ex_aluout,
    input  logic        ex_overflow,
    input  logic        ex_ovf_trap,
    input  logic [31:0] ex_store,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic        ex_regwrite,
    input  reg_sel_t    ex_wsel,
    output logic        ex_ready,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dhit,
    input  logic [31:0] dload,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output reg_sel_t    wb_wsel,
    output logic [31:0] wb_wdat,
    output logic        exc_ovf,
    output logic        exc_addr
);

    mem_state_t state;
    logic       lat_regwrite;

    logic acc_trap;
    logic acc_mem;
    logic acc_misal;
    logic acc_rw;

    // An overflow-trapped op also skips memory: a faulting instruction must
    // not perform its store.
    assign acc_trap  = ex_overflow & ex_ovf_trap;
    assign acc_mem   = ex_memread | ex_memwrite;
    assign acc_misal = ALIGN_CHK & acc_mem & word_misaligned(ex_aluout);
    assign acc_rw    = ex_regwrite & (ex_wsel != '0) & ~acc_trap;

    // Only ACCESS blocks new work; DONE accepts back-to-back.
    assign ex_ready = (state != ACCESS);

    // Stage FSM with registered memory-request and writeback outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            lat_regwrite <= 1'b0;
            dREN         <= 1'b0;
            dWEN         <= 1'b0;
            daddr        <= '0;
            dstore       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_wsel      <= '0;
            wb_wdat      <= '0;
            exc_ovf      <= 1'b0;
            exc_addr     <= 1'b0;
        end else begin
            // Writeback and exception flags are single-cycle pulses.
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            exc_ovf     <= 1'b0;
            exc_addr    <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ex_valid) begin
                        daddr        <= ex_aluout;
                        dstore       <= ex_store;
                        wb_wsel      <= ex_wsel;
                        wb_wdat      <= ex_aluout;
                        lat_regwrite <= acc_rw;
                        if (acc_mem && !acc_misal && !acc_trap) begin
                            state <= ACCESS;
                            dREN  <= ex_memread;
                            dWEN  <= ex_memwrite & ~ex_memread;
                        end else begin
                            state       <= DONE;
                            wb_valid    <= 1'b1;
                            wb_regwrite <= acc_rw & ~acc_misal;
                            exc_ovf     <= acc_trap;
                            exc_addr    <= acc_misal;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        state       <= DONE;
                        dREN        <= 1'b0;
                        dWEN        <= 1'b0;
                        wb_valid    <= 1'b1;
                        wb_regwrite <= dREN & lat_regwrite;
                        if (dREN) wb_wdat <= dload;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// checked against a rule-level reference model.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid, ex_overflow, ex_ovf_trap;
    logic        ex_memread, ex_memwrite, ex_regwrite;
    logic [31:0] ex_aluout, ex_store;
    reg_sel_t    ex_wsel;
    logic        ex_ready, dREN, dWEN, dhit;
    logic [31:0] daddr, dstore, dload;
    logic        wb_valid, wb_regwrite, exc_ovf, exc_addr;
    reg_sel_t    wb_wsel;
    logic [31:0] wb_wdat;

    int checks = 0;
    int errors = 0;

    // {valid, regwrite, exc_ovf, exc_addr, wsel, wdat}
    logic [40:0] wb_obs;
    // {ex_ready, dREN, dWEN, daddr, dstore}
    logic [66:0] mem_obs;
    assign wb_obs  = {wb_valid, wb_regwrite, exc_ovf, exc_addr, wb_wsel, wb_wdat};
    assign mem_obs = {ex_ready, dREN, dWEN, daddr, dstore};

    mem_stage #(.ALIGN_CHK(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_overflow(ex_overflow),
        .ex_ovf_trap(ex_ovf_trap), .ex_store(ex_store),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_regwrite(ex_regwrite), .ex_wsel(ex_wsel), .ex_ready(ex_ready),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_wsel(wb_wsel),
        .wb_wdat(wb_wdat), .exc_ovf(exc_ovf), .exc_addr(exc_addr)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(negedge CLK);
    endtask

    // Present one op for a single edge; returns at the negedge after accept.
    task automatic drive_op(input logic rd, input logic wr, input logic rw,
                            input logic [4:0] wsel, input logic [31:0] alu,
                            input logic [31:0] st, input logic ovf, input logic trap);
        ex_memread = rd; ex_memwrite = wr; ex_regwrite = rw; ex_wsel = wsel;
        ex_aluout = alu; ex_store = st; ex_overflow = ovf; ex_ovf_trap = trap;
        ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick(); tick();
        checks++;
        if (wb_obs !== 41'd0) begin
            errors++; $display("FAIL reset_wb got %h exp %h", wb_obs, 41'd0);
        end
        checks++;
        if (mem_obs !== {1'b1, 66'd0}) begin
            errors++; $display("FAIL reset_mem got %h exp %h", mem_obs, {1'b1, 66'd0});
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_alu;
        drive_op(0, 0, 1, 5'd3, 32'h5, 32'h0, 0, 0);
        checks++;
        if (wb_obs !== {4'b1100, 5'd3, 32'h5}) begin
            errors++; $display("FAIL alu_wb got %h exp %h", wb_obs, {4'b1100, 5'd3, 32'h5});
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL alu_one_cycle got %b exp 0", wb_valid);
        end
    endtask

    task automatic test_load;
        drive_op(1, 0, 1, 5'd7, 32'h100, 32'h0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (mem_obs[66:32] !== {1'b0, 1'b1, 1'b0, 32'h100}) begin
                errors++; $display("FAIL load_req c%0d got %h exp %h", c, mem_obs[66:32], {3'b010, 32'h100});
            end
            if (c == 2) begin dhit = 1'b1; dload = 32'hDEAD_BEEF; end
            tick();
        end
        dhit = 1'b0;
        checks++;
        if (wb_obs !== {4'b1100, 5'd7, 32'hDEAD_BEEF} || dREN !== 1'b0) begin
            errors++; $display("FAIL load_wb got %h dREN %b exp %h dREN 0", wb_obs, dREN, {4'b1100, 5'd7, 32'hDEAD_BEEF});
        end
        tick();
    endtask

    task automatic test_store;
        drive_op(0, 1, 0, 5'd0, 32'h104, 32'h1234, 0, 0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (mem_obs !== {3'b001, 32'h104, 32'h1234}) begin
                errors++; $display("FAIL store_req c%0d got %h exp %h", c, mem_obs, {3'b001, 32'h104, 32'h1234});
            end
            if (c == 1) dhit = 1'b1;
            tick();
        end
        dhit = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || dWEN !== 1'b0) begin
            errors++; $display("FAIL store_wb got v%b rw%b dWEN%b exp v1 rw0 dWEN0", wb_valid, wb_regwrite, dWEN);
        end
        tick();
    endtask

    task automatic test_misaligned;
        drive_op(1, 0, 1, 5'd4, 32'h102, 32'h0, 0, 0);
        checks++;
        if (wb_obs[40:37] !== 4'b1001 || dREN !== 1'b0 || dWEN !== 1'b0) begin
            errors++; $display("FAIL misaligned got flags %b dREN %b dWEN %b exp 1001 0 0", wb_obs[40:37], dREN, dWEN);
        end
        tick();
        checks++;
        if (exc_addr !== 1'b0) begin
            errors++; $display("FAIL misaligned_pulse got %b exp 0", exc_addr);
        end
    endtask

    task automatic test_overflow;
        drive_op(0, 0, 1, 5'd9, 32'h8000_0000, 32'h0, 1, 1);
        checks++;
        if (wb_obs[40:37] !== 4'b1010) begin
            errors++; $display("FAIL ovf_trap got %b exp 1010", wb_obs[40:37]);
        end
        tick();
        drive_op(0, 0, 1, 5'd9, 32'h8000_0000, 32'h0, 1, 0);
        checks++;
        if (wb_obs !== {4'b1100, 5'd9, 32'h8000_0000}) begin
            errors++; $display("FAIL ovf_notrap got %h exp %h", wb_obs, {4'b1100, 5'd9, 32'h8000_0000});
        end
        tick();
    endtask

    task automatic test_r0;
        drive_op(0, 0, 1, 5'd0, 32'h77, 32'h0, 0, 0);
        checks++;
        if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0) begin
            errors++; $display("FAIL r0 got v%b rw%b exp v1 rw0", wb_valid, wb_regwrite);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        drive_op(0, 0, 1, 5'd1, 32'hA, 32'h0, 0, 0);
        checks++;
        if (ex_ready !== 1'b1 || wb_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_done got ready %b v %b exp 1 1", ex_ready, wb_valid);
        end
        drive_op(0, 0, 1, 5'd2, 32'hB, 32'h0, 0, 0);
        checks++;
        if (wb_obs !== {4'b1100, 5'd2, 32'hB}) begin
            errors++; $display("FAIL b2b_second got %h exp %h", wb_obs, {4'b1100, 5'd2, 32'hB});
        end
        tick();
    endtask

    task automatic test_reset_mid_access;
        drive_op(1, 0, 1, 5'd5, 32'h200, 32'h0, 0, 0);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (mem_obs !== {1'b1, 66'd0} || wb_obs !== 41'd0) begin
            errors++; $display("FAIL rst_mid got mem %h wb %h exp mem %h wb 0", mem_obs, wb_obs, {1'b1, 66'd0});
        end
        dhit = 1'b1;
        tick(); tick();
        dhit = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_stale_hit got v %b ready %b exp 0 1", wb_valid, ex_ready);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            int unsigned kind  = $urandom_range(0, 3);
            logic        rd    = (kind == 1) || (kind == 3);
            logic        wr    = (kind == 2) || (kind == 3);
            logic        rw    = ($urandom_range(0, 3) != 0);
            logic [4:0]  wsel  = 5'($urandom_range(0, 31));
            logic [31:0] alu   = $urandom;
            logic [31:0] st    = $urandom;
            logic [31:0] ld    = $urandom;
            logic        ovf   = (kind == 0) && ($urandom_range(0, 3) == 0);
            logic        trap  = ($urandom_range(0, 1) == 1);
            int unsigned delay = $urandom_range(0, 3);
            logic        is_mem, misal, trapped, exp_rw;
            logic [31:0] exp_dat;
            if (rd || wr) alu[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            is_mem  = rd || wr;
            misal   = is_mem && (alu % 4 != 0);
            trapped = ovf && trap;
            exp_dat = alu;
            drive_op(rd, wr, rw, wsel, alu, st, ovf, trap);
            if (is_mem && !misal) begin
                for (int c = 0; c <= int'(delay); c++) begin
                    checks++;
                    if (mem_obs !== {1'b0, rd, wr && !rd, alu, st}) begin
                        errors++; $display("FAIL rnd_req n%0d c%0d got %h exp %h", n, c, mem_obs, {1'b0, rd, wr && !rd, alu, st});
                    end
                    if (c == int'(delay)) begin dhit = 1'b1; dload = ld; end
                    tick();
                end
                dhit = 1'b0;
                exp_rw = rd && rw && (wsel != 0);
                if (rd) exp_dat = ld;
            end else begin
                exp_rw = rw && (wsel != 0) && !trapped && !misal;
            end
            checks++;
            if (wb_obs !== {1'b1, exp_rw, trapped, misal, wsel, exp_dat} || dREN !== 1'b0 || dWEN !== 1'b0) begin
                errors++; $display("FAIL rnd_wb n%0d got %h exp %h", n, wb_obs, {1'b1, exp_rw, trapped, misal, wsel, exp_dat});
            end
            // Idle cycle with a stray dhit that must be ignored.
            dhit = $urandom_range(0, 1) == 1;
            tick();
            dhit = 1'b0;
            checks++;
            if (wb_valid !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0 || ex_ready !== 1'b1) begin
                errors++; $display("FAIL rnd_idle n%0d got v%b ren%b wen%b rdy%b exp 0 0 0 1", n, wb_valid, dREN, dWEN, ex_ready);
            end
        end
    endtask

    initial begin
        RST = 1'b1; ex_valid = 1'b0; ex_aluout = '0; ex_overflow = 1'b0;
        ex_ovf_trap = 1'b0; ex_store = '0; ex_memread = 1'b0; ex_memwrite = 1'b0;
        ex_regwrite = 1'b0; ex_wsel = '0; dhit = 1'b0; dload = '0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_overflow();
        test_r0();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ALIGN_CHK, default 1, meaning the word-alignment check on load/store addresses is enabled.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports ex_valid input 1, ex_aluout input 32, ex_overflow input 1, ex_ovf_trap input 1, ex_store input 32: result and flags from the execute-stage ALU, plus store data.
REQ-005 SHALL have ports ex_memread input 1, ex_memwrite input 1, ex_regwrite input 1, ex_wsel input 5: execute-stage control.
REQ-006 SHALL have port ex_ready  output  1  high when the stage accepts an EX result this cycle.
REQ-007 SHALL have ports dREN output 1, dWEN output 1, daddr output 32, dstore output 32, dhit input 1, dload input 32: data-memory request/response.
REQ-008 SHALL have ports wb_valid output 1, wb_regwrite output 1, wb_wsel output 5, wb_wdat output 32: registered writeback outputs.
REQ-009 SHALL have ports exc_ovf output 1, exc_addr output 1: one-cycle exception pulses, aligned with wb_valid.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-011 In IDLE, ex_ready SHALL be 1; ex_valid=1 latches all ex_* inputs.
REQ-012 A latched non-memory op SHALL go to DONE; wb_valid=1 on the next cycle (1-cycle latency) with wb_wdat=aluout.
REQ-013 A latched load/store with a valid address SHALL go to ACCESS; daddr/dstore come from latched values; dREN=memread, dWEN=memwrite, held stable until dhit.
REQ-014 In ACCESS, ex_ready SHALL be 0; on dhit=1, a load SHALL capture dload into wb_wdat; a store SHALL leave wb_regwrite=0; next state DONE.
REQ-015 dREN and dWEN SHALL never both be 1; if memread and memwrite are both latched, memread takes priority.
REQ-016 In DONE, wb_valid SHALL be 1 for exactly one cycle, then the state returns to IDLE; ex_ready SHALL be 1 in DONE (back-to-back accept).
REQ-017 ex_overflow=1 with ex_ovf_trap=1 SHALL force wb_regwrite=0 and pulse exc_ovf with wb_valid; with ex_ovf_trap=0 (unsigned ops), overflow SHALL be ignored.
REQ-018 With ALIGN_CHK=1, a load/store with aluout[1:0]!=0 SHALL issue no dREN/dWEN, go to DONE, force wb_regwrite=0, and pulse exc_addr.
REQ-019 wb_wsel=0 SHALL force wb_regwrite=0 (no write to r0).
REQ-020 dhit in IDLE or DONE SHALL be ignored.
REQ-021 ex_valid=0 in IDLE SHALL keep IDLE with wb_valid=0.

Reset
REQ-022 On RST=1 at a clock edge: state=IDLE; dREN=dWEN=0; wb_valid=wb_regwrite=0; wb_wsel=0; wb_wdat=0; exc_ovf=exc_addr=0; daddr=dstore=0.
REQ-023 RST during ACCESS SHALL abandon the request (dREN/dWEN low the following cycle) with no wb_valid for that op.

Structure
REQ-024 The state enum and the 5-bit register-select typedef SHALL live in cpu_types_pkg; the ALIGN_CHK default stays local.
REQ-025 The block SHALL be a single module; no sub-module.

Verification
REQ-026 ALU op, aluout=0x0000_0005, wsel=3, regwrite=1 -> next cycle wb_valid=1, wb_wdat=5, wb_wsel=3.
REQ-027 Load at 0x100, dhit asserted after 3 cycles with dload=0xDEAD_BEEF -> dREN held 3 cycles, ex_ready=0 meanwhile, then wb_wdat=0xDEAD_BEEF.
REQ-028 Store at 0x104 with data 0x1234 -> dWEN=1, daddr=0x104, dstore=0x1234 until dhit; wb_regwrite=0.
REQ-029 Load at 0x102 -> no dREN, exc_addr pulse, wb_regwrite=0.
REQ-030 Add overflow with trap=1 -> exc_ovf=1, wb_regwrite=0; same with trap=0 -> normal writeback.
REQ-031 RST asserted mid-ACCESS -> dREN=0 next cycle, wb_valid stays 0, state IDLE.
